mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
- Sequencing controller for the KGP-RISC multiply path.
- Computes a 32x32 -> 64-bit product iteratively with radix-2 Booth over 33 steps, signed or unsigned, and holds the result in HIGH/LOW registers for the register file.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while the multiply runs.
- Reuses the M / Q0 / LOW / HIGH operand and result naming of the combinational signed multiplier, so the two are drop-in interchangeable behind the ALU mux.

Parameters:
- WIDTH, 32, operand width; LOW and HIGH are each WIDTH bits.
- STEPS, WIDTH+1, number of Booth iterations (operands extended by one bit).

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  request a multiply; sampled only in IDLE
- SIGNED_OP  in  1  1 = signed (two's complement), 0 = unsigned; sampled with START
- ABORT  in  1  synchronous cancel of an in-flight multiply
- M  in  WIDTH  multiplicand; sampled with START
- Q0  in  WIDTH  multiplier; sampled with START
- BUSY  out  1  high while in RUN
- DONE  out  1  one-cycle pulse when LOW/HIGH have just been updated
- LOW  out  WIDTH  product bits [WIDTH-1:0], registered
- HIGH  out  WIDTH  product bits [2*WIDTH-1:WIDTH], registered

Behaviour:
- Reset (RST=1, asynchronous): state IDLE. BUSY=0, DONE=0, LOW=0, HIGH=0. Internal A, Q, q_-1 and step counter all 0.
- States: IDLE and RUN.
- IDLE, START=1 at edge k:
  - Load Mx = {ext, M} and Qx = {ext, Q0}, both WIDTH+1 bits. ext is the MSB when SIGNED_OP=1, else 0.
  - Clear A (WIDTH+1 bits) and q_-1; counter = 0; go to RUN.
  - BUSY=1 from edge k.
- RUN, each edge, one Booth step on {A, Qx, q_-1}:
  - {Qx[0], q_-1} = 01: A += Mx.
  - 10: A -= Mx.
  - 00 / 11: no add.
  - Then arithmetic right shift of {A, Qx, q_-1} by 1; counter += 1.
  - All arithmetic is modulo 2^(WIDTH+1) on A.
- Completion: on the edge performing step STEPS (edge k+33 at default):
  - HIGH/LOW are loaded with bits [2*WIDTH-1:0] of the final {A, Qx}, using the post-shift value.
  - DONE=1 for exactly that cycle; BUSY=0; state IDLE.
  - Latency: START edge to DONE = 33 cycles.
- LOW/HIGH change only on a completion edge or on reset. They are stable at all other times, including during RUN.
- START while BUSY=1: ignored; no queuing.
- START in the cycle DONE=1: accepted (state is already IDLE), giving back-to-back operation with no idle bubble.
- ABORT=1 in RUN: return to IDLE at the next edge. BUSY=0, no DONE, LOW/HIGH keep their previous values. ABORT has priority over completion on the same edge.
- ABORT in IDLE: no effect. If START and ABORT are both high in IDLE, START wins.
- RST mid-operation: immediate return to the reset state; LOW/HIGH are cleared.
- Operand changes on M/Q0/SIGNED_OP after the START edge have no effect on the running operation.
- Signed overflow cannot occur: the 64-bit result is exact for all inputs, including 0x80000000 x 0x80000000.

Test Plan:
- Signed, M=0x00000002, Q0=0xFFFFFFFF, START 1 cycle -> after 33 cycles DONE=1 for 1 cycle; HIGH=0xFFFFFFFF, LOW=0xFFFFFFFE; BUSY high for 33 cycles.
- Signed back-to-back:
  - M=2, Q0=2 -> LOW=0x00000004, HIGH=0.
  - START reasserted during the DONE cycle with M=2, Q0=6 -> LOW=0x0000000C, HIGH=0 exactly 33 cycles later.
- Signed negative x negative: M=0xFFFFFFF9, Q0=0xFFFFFFF3 -> LOW=0x0000005B, HIGH=0. The same operands with SIGNED_OP=0 -> HIGH=0xFFFFFFEC, LOW=0x0000005B.
- Corner cases:
  - Unsigned M=0xFFFFFFFF, Q0=0x00000002 -> HIGH=0x00000001, LOW=0xFFFFFFFE.
  - Signed 0x80000000 x 0x80000000 -> HIGH=0x40000000, LOW=0.
- ABORT at cycle 10 of RUN (previous result HIGH=0, LOW=4) -> BUSY drops next edge, no DONE pulse, LOW/HIGH still 0/4. A START during RUN before the abort is ignored.
- RST pulse asynchronously at cycle 20 of RUN -> BUSY, DONE, LOW, HIGH all 0 immediately. A subsequent START with M=2, Q0=6 completes normally with LOW=0x0000000C.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Iterative radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Latency STEPS cycles START->DONE; START ignored while BUSY, ABORT cancels a run without touching LOW/HIGH.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED_OP,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Q0,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] LOW,
    output logic [WIDTH-1:0] HIGH
);

    localparam int XW = WIDTH + 1;
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [XW-1:0]    mx_q;
    logic [XW-1:0]    a_q;
    logic [XW-1:0]    qx_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] high_q;

    logic [XW-1:0]    a_sum;
    logic [XW-1:0]    a_d;
    logic [XW-1:0]    qx_d;
    logic             qm1_d;
    logic             last_step;
    logic             ext_m;
    logic             ext_q;

    assign ext_m     = SIGNED_OP & M[WIDTH-1];
    assign ext_q     = SIGNED_OP & Q0[WIDTH-1];
    assign last_step = (cnt_q == CW'(STEPS - 1));

    // One Booth step: conditional add/subtract, then arithmetic shift of {A, Qx, q_-1}.
    always_comb begin
        a_sum = a_q;
        case ({qx_q[0], qm1_q})
            2'b01:   a_sum = a_q + mx_q;
            2'b10:   a_sum = a_q - mx_q;
            default: a_sum = a_q;
        endcase
        a_d   = {a_sum[XW-1], a_sum[XW-1:1]};
        qx_d  = {a_sum[0], qx_q[XW-1:1]};
        qm1_d = qx_q[0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            mx_q    <= '0;
            a_q     <= '0;
            qx_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            low_q   <= '0;
            high_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        mx_q    <= {ext_m, M};
                        qx_q    <= {ext_q, Q0};
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (ABORT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        a_q   <= a_d;
                        qx_q  <= qx_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            // The product's low 2*WIDTH bits straddle the A/Qx boundary by one bit.
                            low_q   <= qx_d[WIDTH-1:0];
                            high_q  <= {a_d[WIDTH-2:0], qx_d[XW-1]};
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign LOW  = low_q;
    assign HIGH = high_q;

endmodule
